pipe_elastic_chain: RTL and testbench



---
 rtl/poly_pkg.sv | 7 +
 rtl/pipe_elastic_stage.sv | 38 +++
 rtl/pipe_elastic_chain.sv | 100 ++++++++++
 tb/tb_pipe_elastic_chain.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_pkg.sv
// Shared constants for the poly_mul pipeline datapath.
package poly_pkg;

    localparam int unsigned FIELD_W            = 256;
    localparam int unsigned PIPE_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/pipe_elastic_stage.sv
// One elastic pipeline slot: a valid bit plus a payload register with load enable.
// A loaded bubble clears the valid bit but leaves the payload untouched.
module pipe_elastic_stage
    import poly_pkg::*;
#(
    parameter int unsigned WIDTH = FIELD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_elastic_chain.sv
// Elastic valid/ready register chain of DEPTH stages with collapsing bubbles and flush.
// Optional stall counter output enabled by defining STALL_CNT_EN.
module pipe_elastic_chain
    import poly_pkg::*;
#(
    parameter int unsigned WIDTH = FIELD_W,
    parameter int unsigned DEPTH = PIPE_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_elastic_chain: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_d     [DEPTH];
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_occ;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // A slot can move when the sink drains or any slot from here to the tail is empty.
        assign w_rdy[k] = out_ready | ~(&w_v[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign w_src_v[k] = in_valid & ~flush;
            assign w_src_d[k] = in_data;
        end else begin : g_body
            assign w_src_v[k] = w_v[k-1];
            assign w_src_d[k] = w_d[k-1];
        end

        pipe_elastic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (flush),
            .i_load  (w_rdy[k]),
            .i_valid (w_src_v[k]),
            .i_data  (w_src_d[k]),
            .o_valid (w_v[k]),
            .o_data  (w_d[k])
        );
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign out_valid = w_v[DEPTH-1];
    assign out_data  = w_d[DEPTH-1];

    assign w_push = in_valid & in_ready;
    assign w_pop  = w_v[DEPTH-1] & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign occupancy = r_occ;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (flush) begin
            r_stall <= '0;
        end else if (w_v[DEPTH-1] && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed bench for pipe_elastic_chain (WIDTH=256, DEPTH=4); stall counter tested when
// STALL_CNT_EN is defined.
module tb_pipe_elastic_chain;

    localparam int unsigned W = 256;
    localparam int unsigned D = 4;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;
`ifdef STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    pipe_elastic_chain #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        int occ_exp [7];
        occ_exp = '{1, 2, 3, 3, 2, 1, 0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_data", out_data, W'(0));
        chk("reset_occupancy", W'(occupancy), W'(0));
        chk("reset_in_ready", W'(in_ready), W'(1));
        tick();
        rst = 1'b0;

        // Streaming: 1,2,3 back-to-back with out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'(1);
        for (int i = 1; i <= 7; i++) begin
            tick();
            in_valid = (i < 3);
            in_data  = W'(i + 1);
            chk($sformatf("stream_occ_%0d", i), W'(occupancy), W'(occ_exp[i-1]));
            chk($sformatf("stream_valid_%0d", i), W'(out_valid), W'((i >= 4) && (i <= 6)));
            if (i >= 4 && i <= 6) begin
                chk($sformatf("stream_data_%0d", i), out_data, W'(i - 3));
            end
        end
        in_valid = 1'b0;

        // Backpressure: 4 accepted while stalled, remaining 2 as slots drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'(i + 1);
            #1;
            chk($sformatf("bp_in_ready_%0d", i), W'(in_ready), W'(1));
            tick();
        end
        chk("bp_full_occ", W'(occupancy), W'(4));
        chk("bp_full_valid", W'(out_valid), W'(1));
        chk("bp_full_data", out_data, W'(1));
        in_data = W'(5);
        #1;
        chk("bp_in_ready_full", W'(in_ready), W'(0));
        tick();
        chk("bp_hold_occ", W'(occupancy), W'(4));
        chk("bp_hold_data", out_data, W'(1));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", W'(in_ready), W'(1));
        tick();
        chk("bp_rel_data_2", out_data, W'(2));
        chk("bp_rel_occ_a", W'(occupancy), W'(4));
        in_data = W'(6);
        tick();
        chk("bp_rel_data_3", out_data, W'(3));
        chk("bp_rel_occ_b", W'(occupancy), W'(4));
        in_valid = 1'b0;
        for (int j = 4; j <= 6; j++) begin
            tick();
            chk($sformatf("bp_drain_data_%0d", j), out_data, W'(j));
            chk($sformatf("bp_drain_occ_%0d", j), W'(occupancy), W'(7 - j));
        end
        tick();
        chk("bp_empty_valid", W'(out_valid), W'(0));
        chk("bp_empty_occ", W'(occupancy), W'(0));

        // Bubble collapse: A, two idle cycles, B, output stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = W'('hB);
        tick();
        in_valid = 1'b0;
        chk("bub_occ", W'(occupancy), W'(2));
        chk("bub_valid", W'(out_valid), W'(1));
        chk("bub_data_a", out_data, W'('hA));
        tick();
        tick();
        chk("bub_occ_hold", W'(occupancy), W'(2));
        out_ready = 1'b1;
        tick();
        chk("bub_data_b", out_data, W'('hB));
        chk("bub_valid_b", W'(out_valid), W'(1));
        chk("bub_occ_b", W'(occupancy), W'(1));
        tick();
        chk("bub_empty", W'(out_valid), W'(0));

        // Flush with a full chain and a concurrent in_valid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'('h21 + i);
            tick();
        end
        chk("fl_full_occ", W'(occupancy), W'(4));
        flush   = 1'b1;
        in_data = W'('h99);
        #1;
        chk("fl_in_ready", W'(in_ready), W'(0));
        chk("fl_out_visible", W'(out_valid), W'(1));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", W'(occupancy), W'(0));
        chk("fl_valid", W'(out_valid), W'(0));
        chk("fl_data_hold", out_data, W'('h21));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("fl_not_taken", W'(out_valid), W'(0));

        // Async reset mid-stream, asserted between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h31);
        tick();
        in_data = W'('h32);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_pre_data", out_data, W'('h31));
        chk("rst_pre_occ", W'(occupancy), W'(2));
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", W'(out_valid), W'(0));
        chk("rst_async_data", out_data, W'(0));
        chk("rst_async_occ", W'(occupancy), W'(0));
        chk("rst_async_in_ready", W'(in_ready), W'(1));
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = W'('h41);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_after_valid", W'(out_valid), W'(1));
        chk("rst_after_data", out_data, W'('h41));
        tick();
        chk("rst_after_empty", W'(out_valid), W'(0));

`ifdef STALL_CNT_EN
        // Stall counter: 10 stalled cycles, then flush clears it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h51);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_pre", W'(stall_cnt), W'(0));
        for (int i = 0; i < 10; i++) tick();
        chk("stall_10", W'(stall_cnt), W'(10));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stall_flush", W'(stall_cnt), W'(0));
        chk("stall_flush_occ", W'(occupancy), W'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
